// File: rtl/braille_cell_driver.sv
// Coil sequencer for one 8-dot latching-solenoid braille cell.
// Turns pattern changes into release/gap/set/cooldown pulse trains so raise and lower coils never overlap.
module braille_cell_driver #(
    parameter int unsigned PULSE_CYCLES    = 1000,
    parameter int unsigned GAP_CYCLES      = 100,
    parameter int unsigned COOLDOWN_CYCLES = 500,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cell_in,
    input  logic       enable,
    input  logic       refresh,
    output logic [7:0] pin_up,
    output logic [7:0] pin_down,
    output logic       busy,
    output logic       cell_done,
    output logic [7:0] applied
);

    localparam longint unsigned CntLimit = 64'd1 << CNT_W;

    if (CNT_W < 1 || CNT_W > 32 ||
        PULSE_CYCLES < 1 || 64'(PULSE_CYCLES) >= CntLimit ||
        GAP_CYCLES < 1 || 64'(GAP_CYCLES) >= CntLimit ||
        COOLDOWN_CYCLES < 1 || 64'(COOLDOWN_CYCLES) >= CntLimit) begin : gen_param_check
        $error("braille_cell_driver: phase lengths must be >= 1 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] PulseLoad = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GapLoad   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CoolLoad  = CNT_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRelease,
        StGap,
        StSet,
        StCooldown
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cur_q, cur_d;
    logic [7:0]       dn_q, dn_d;
    logic [7:0]       up_q, up_d;
    logic [7:0]       applied_q, applied_d;
    logic             dirty_q, dirty_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic [7:0]       pin_up_q, pin_up_d;
    logic [7:0]       pin_down_q, pin_down_d;

    logic             full_drive;
    logic [7:0]       dn_calc;
    logic [7:0]       up_calc;
    logic             start;
    logic             cnt_zero;

    // Unknown physical state (or an explicit refresh) drives every pin, not just the delta.
    assign full_drive = dirty_q | refresh | pend_q;
    assign dn_calc    = full_drive ? ~cell_in : (applied_q & ~cell_in);
    assign up_calc    = full_drive ? cell_in : (cell_in & ~applied_q);
    assign start      = enable & ((cell_in != applied_q) | full_drive);
    assign cnt_zero   = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        dn_d      = dn_q;
        up_d      = up_q;
        applied_d = applied_q;
        dirty_d   = dirty_q;
        pend_d    = pend_q;
        done_d    = 1'b0;

        if (state_q != StIdle && refresh) begin
            pend_d = 1'b1;
        end

        if (state_q != StIdle && !enable) begin
            // Abort leaves the pins in an unknown mix, so force a full drive next time.
            state_d = StIdle;
            dirty_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cur_d  = cell_in;
                        dn_d   = dn_calc;
                        up_d   = up_calc;
                        pend_d = 1'b0;
                        if (dn_calc != 8'h00) begin
                            state_d = StRelease;
                            cnt_d   = PulseLoad;
                        end else if (up_calc != 8'h00) begin
                            state_d = StSet;
                            cnt_d   = PulseLoad;
                        end else begin
                            state_d = StCooldown;
                            cnt_d   = CoolLoad;
                        end
                    end
                end
                StRelease: begin
                    if (cnt_zero) begin
                        if (up_q != 8'h00) begin
                            state_d = StGap;
                            cnt_d   = GapLoad;
                        end else begin
                            state_d = StCooldown;
                            cnt_d   = CoolLoad;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StGap: begin
                    if (cnt_zero) begin
                        state_d = StSet;
                        cnt_d   = PulseLoad;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StSet: begin
                    if (cnt_zero) begin
                        state_d   = StCooldown;
                        cnt_d     = CoolLoad;
                        applied_d = cur_q;
                        dirty_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StCooldown: begin
                    if (cnt_zero) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        // Release-only or empty actuations never passed through SET.
                        if (up_q == 8'h00) begin
                            applied_d = cur_q;
                            dirty_d   = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    dirty_d = 1'b1;
                end
            endcase
        end

        // Coil drive follows the state being entered so it is registered alongside it.
        pin_down_d = (state_d == StRelease) ? dn_d : 8'h00;
        pin_up_d   = (state_d == StSet) ? up_d : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cur_q      <= 8'h00;
            dn_q       <= 8'h00;
            up_q       <= 8'h00;
            applied_q  <= 8'h00;
            dirty_q    <= 1'b1;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            pin_up_q   <= 8'h00;
            pin_down_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            dn_q       <= dn_d;
            up_q       <= up_d;
            applied_q  <= applied_d;
            dirty_q    <= dirty_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            pin_up_q   <= pin_up_d;
            pin_down_q <= pin_down_d;
        end
    end

    assign pin_up    = pin_up_q;
    assign pin_down  = pin_down_q;
    assign busy      = (state_q != StIdle);
    assign cell_done = done_q;
    assign applied   = applied_q;

    a_coil_exclusive : assert property (@(posedge clk) disable iff (!reset)
        (pin_up & pin_down) == 8'h00);
    a_down_then_up : assert property (@(posedge clk) disable iff (!reset)
        (pin_down != 8'h00) |=> (pin_up == 8'h00));
    a_up_then_down : assert property (@(posedge clk) disable iff (!reset)
        (pin_up != 8'h00) |=> (pin_down == 8'h00));

endmodule

// File: tb/tb_braille_cell_driver.sv
// Bench for braille_cell_driver: directed scenarios plus random traffic against a
// transaction-level model that expands each actuation into its expected per-cycle timeline.
module tb_braille_cell_driver;

    localparam int unsigned P = 4;
    localparam int unsigned G = 2;
    localparam int unsigned C = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] cell_in = 8'h00;
    logic       enable = 1'b0;
    logic       refresh = 1'b0;
    logic [7:0] pin_up;
    logic [7:0] pin_down;
    logic       busy;
    logic       cell_done;
    logic [7:0] applied;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [7:0] up;
        logic [7:0] down;
        logic [7:0] applied;
    } obs_t;

    obs_t       exp_o;
    obs_t       plan[$];
    logic       m_dirty;
    logic       m_pend;
    logic [7:0] m_final;

    always #5 clk = ~clk;

    braille_cell_driver #(
        .PULSE_CYCLES   (P),
        .GAP_CYCLES     (G),
        .COOLDOWN_CYCLES(C),
        .CNT_W          (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cell_in  (cell_in),
        .enable   (enable),
        .refresh  (refresh),
        .pin_up   (pin_up),
        .pin_down (pin_down),
        .busy     (busy),
        .cell_done(cell_done),
        .applied  (applied)
    );

    function automatic obs_t act();
        obs_t o;
        o.busy = busy; o.done = cell_done; o.up = pin_up; o.down = pin_down; o.applied = applied;
        return o;
    endfunction

    function automatic obs_t mk(input logic [7:0] u, input logic [7:0] d, input logic [7:0] a);
        obs_t o;
        o.busy = 1'b1; o.done = 1'b0; o.up = u; o.down = d; o.applied = a;
        return o;
    endfunction

    task automatic model_reset();
        plan.delete();
        exp_o   = '0;
        m_dirty = 1'b1;
        m_pend  = 1'b0;
        m_final = 8'h00;
    endtask

    // Drive one cycle of inputs, predict the next cycle, then step to 1 time unit past the edge.
    task automatic tick(input logic [7:0] ci, input logic en, input logic rf);
        obs_t       nxt;
        logic       full;
        logic [7:0] dn;
        logic [7:0] up;
        logic [7:0] app;
        cell_in = ci; enable = en; refresh = rf;
        nxt = '0;
        nxt.applied = exp_o.applied;
        app = exp_o.applied;
        if (exp_o.busy) begin
            if (rf) m_pend = 1'b1;
            if (!en) begin
                plan.delete();
                m_dirty = 1'b1;
            end else if (plan.size() > 0) begin
                nxt = plan.pop_front();
            end else begin
                nxt.done = 1'b1;
                nxt.applied = m_final;
                m_dirty = 1'b0;
            end
        end else begin
            full = m_dirty | rf | m_pend;
            if (en && (ci != app || full)) begin
                dn = full ? ~ci : (app & ~ci);
                up = full ? ci : (ci & ~app);
                m_pend = 1'b0;
                m_final = ci;
                if (dn != 8'h00) repeat (P) plan.push_back(mk(8'h00, dn, app));
                if (dn != 8'h00 && up != 8'h00) repeat (G) plan.push_back(mk(8'h00, 8'h00, app));
                if (up != 8'h00) repeat (P) plan.push_back(mk(up, 8'h00, app));
                repeat (C) plan.push_back(mk(8'h00, 8'h00, (up != 8'h00) ? ci : app));
                nxt = plan.pop_front();
            end
        end
        exp_o = nxt;
        @(posedge clk);
        #1;
    endtask

    // Coil exclusivity and no back-to-back raise/lower across adjacent cycles.
    logic [7:0] prev_up = 8'h00;
    logic [7:0] prev_dn = 8'h00;
    always @(negedge clk) begin
        if (reset) begin
            n_cmp++;
            if ((pin_up & pin_down) !== 8'h00 || (prev_dn != 8'h00 && pin_up != 8'h00) ||
                (prev_up != 8'h00 && pin_down != 8'h00)) begin
                n_err++;
                $display("FAIL coil_rule: up=%h down=%h prev_up=%h prev_down=%h, required no overlap",
                         pin_up, pin_down, prev_up, prev_dn);
            end
        end
        prev_up = pin_up;
        prev_dn = pin_down;
    end

    task automatic test_reset();
        model_reset();
        #2;
        n_cmp++;
        if (act() !== exp_o) begin
            n_err++;
            $display("FAIL reset_async: got %h required %h", act(), exp_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (act() !== exp_o) begin
            n_err++;
            $display("FAIL reset_held: got %h required %h", act(), exp_o);
        end
        #3 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(8'h00, 1'b0, 1'b0);
            n_cmp++;
            if (act() !== exp_o) begin
                n_err++;
                $display("FAIL reset_idle c%0d: got %h required %h", i, act(), exp_o);
            end
        end
    endtask

    task automatic test_full_drive();
        int n_busy = 0, n_dn = 0, n_up = 0, n_done = 0;
        for (int i = 0; i < 15; i++) begin
            tick(8'h17, 1'b1, 1'b0);
            n_cmp++;
            if (act() !== exp_o) begin
                n_err++;
                $display("FAIL full_drive c%0d: got %h required %h", i, act(), exp_o);
            end
            n_busy += int'(busy); n_done += int'(cell_done);
            n_dn += int'(pin_down == 8'hE8); n_up += int'(pin_up == 8'h17);
        end
        n_cmp++;
        if (n_busy != 13 || n_dn != 4 || n_up != 4 || n_done != 1 || applied !== 8'h17) begin
            n_err++;
            $display("FAIL full_drive_shape: busy=%0d dn=%0d up=%0d done=%0d app=%h required 13 4 4 1 17",
                     n_busy, n_dn, n_up, n_done, applied);
        end
    endtask

    task automatic test_release_only();
        int n_busy = 0, n_dn = 0, n_up = 0, n_done = 0;
        for (int i = 0; i < 9; i++) begin
            tick(8'h01, 1'b1, 1'b0);
            n_cmp++;
            if (act() !== exp_o) begin
                n_err++;
                $display("FAIL release_only c%0d: got %h required %h", i, act(), exp_o);
            end
            n_busy += int'(busy); n_done += int'(cell_done);
            n_dn += int'(pin_down == 8'h16); n_up += int'(pin_up != 8'h00);
        end
        n_cmp++;
        if (n_busy != 7 || n_dn != 4 || n_up != 0 || n_done != 1 || applied !== 8'h01) begin
            n_err++;
            $display("FAIL release_only_shape: busy=%0d dn=%0d up=%0d done=%0d app=%h required 7 4 0 1 01",
                     n_busy, n_dn, n_up, n_done, applied);
        end
    endtask

    task automatic test_coalesce();
        int n_up2 = 0, n_up4 = 0, n_other = 0, n_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick((i < 2) ? 8'h03 : 8'h07, 1'b1, 1'b0);
            n_cmp++;
            if (act() !== exp_o) begin
                n_err++;
                $display("FAIL coalesce c%0d: got %h required %h", i, act(), exp_o);
            end
            n_up2 += int'(pin_up == 8'h02); n_up4 += int'(pin_up == 8'h04);
            n_other += int'(pin_down != 8'h00 || (pin_up != 8'h00 && pin_up != 8'h02 && pin_up != 8'h04));
            n_done += int'(cell_done);
        end
        n_cmp++;
        if (n_up2 != 4 || n_up4 != 4 || n_other != 0 || n_done != 2 || applied !== 8'h07) begin
            n_err++;
            $display("FAIL coalesce_shape: up02=%0d up04=%0d other=%0d done=%0d app=%h required 4 4 0 2 07",
                     n_up2, n_up4, n_other, n_done, applied);
        end
    endtask

    task automatic test_enable_abort();
        int n_up = 0;
        bit hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick(8'h70, 1'b1, 1'b0);
            n_cmp++;
            if (act() !== exp_o) begin
                n_err++;
                $display("FAIL abort_lead c%0d: got %h required %h", i, act(), exp_o);
            end
            hit = (pin_up != 8'h00);
        end
        if (!hit) begin
            n_err++;
            $display("FAIL abort_wait_set: no SET phase within 20 cycles, required one");
        end
        tick(8'h70, 1'b1, 1'b0);
        tick(8'h70, 1'b0, 1'b0);
        n_cmp++;
        if (pin_up !== 8'h00 || pin_down !== 8'h00 || busy !== 1'b0 || cell_done !== 1'b0 ||
            applied !== 8'h07) begin
            n_err++;
            $display("FAIL abort_now: up=%h dn=%h busy=%b done=%b app=%h required 00 00 0 0 07",
                     pin_up, pin_down, busy, cell_done, applied);
        end
        for (int i = 0; i < 3; i++) begin
            tick(8'h70, 1'b0, 1'b0);
            n_cmp++;
            if (act() !== exp_o) begin
                n_err++;
                $display("FAIL abort_idle c%0d: got %h required %h", i, act(), exp_o);
            end
        end
        for (int i = 0; i < 15; i++) begin
            tick(8'h07, 1'b1, 1'b0);
            n_cmp++;
            if (act() !== exp_o) begin
                n_err++;
                $display("FAIL abort_redrive c%0d: got %h required %h", i, act(), exp_o);
            end
            if (i == 0) begin
                n_cmp++;
                if (pin_down !== 8'hF8) begin
                    n_err++;
                    $display("FAIL abort_redrive_dn: got %h required f8", pin_down);
                end
            end
            n_up += int'(pin_up == 8'h07);
        end
        n_cmp++;
        if (n_up != 4 || applied !== 8'h07) begin
            n_err++;
            $display("FAIL abort_redrive_shape: up07=%0d app=%h required 4 07", n_up, applied);
        end
    endtask

    task automatic test_refresh();
        int first_done = -1, n_dn = 0, n_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick(8'h07, 1'b1, (i == 0 || i == 3));
            n_cmp++;
            if (act() !== exp_o) begin
                n_err++;
                $display("FAIL refresh c%0d: got %h required %h", i, act(), exp_o);
            end
            if (first_done >= 0 && i == first_done + 1) begin
                n_cmp++;
                if (busy !== 1'b1 || pin_down !== 8'hF8) begin
                    n_err++;
                    $display("FAIL refresh_restart: busy=%b dn=%h required 1 f8", busy, pin_down);
                end
            end
            if (cell_done && first_done < 0) first_done = i;
            n_dn += int'(pin_down == 8'hF8); n_done += int'(cell_done);
        end
        n_cmp++;
        if (n_dn != 8 || n_done != 2) begin
            n_err++;
            $display("FAIL refresh_shape: dnF8=%0d done=%0d required 8 2", n_dn, n_done);
        end
    endtask

    task automatic test_random();
        logic [7:0] ci;
        logic       en, rf;
        ci = exp_o.applied;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) ci = 8'($urandom);
            en = ($urandom_range(0, 29) != 0);
            rf = ($urandom_range(0, 29) == 0);
            tick(ci, en, rf);
            n_cmp++;
            if (act() !== exp_o) begin
                n_err++;
                $display("FAIL random c%0d: got %h required %h", i, act(), exp_o);
            end
        end
    endtask

    task automatic test_reset_mid_release();
        logic [7:0] ci;
        ci = cell_in;
        for (int i = 0; i < 40; i++) begin
            tick(ci, 1'b1, 1'b0);
            n_cmp++;
            if (act() !== exp_o) begin
                n_err++;
                $display("FAIL drain c%0d: got %h required %h", i, act(), exp_o);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL drain_idle: busy=%b required 0", busy);
        end
        ci = ~applied;
        tick(ci, 1'b1, 1'b0);
        tick(ci, 1'b1, 1'b0);
        n_cmp++;
        if (act() !== exp_o || pin_down == 8'h00) begin
            n_err++;
            $display("FAIL mid_release_pre: got %h required %h", act(), exp_o);
        end
        #2 reset = 1'b0;
        enable = 1'b0;
        #1;
        n_cmp++;
        if (pin_down !== 8'h00 || pin_up !== 8'h00 || busy !== 1'b0 || applied !== 8'h00 ||
            cell_done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_release_async: dn=%h up=%h busy=%b app=%h done=%b required 00 00 0 00 0",
                     pin_down, pin_up, busy, applied, cell_done);
        end
        model_reset();
        #3 reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(ci, 1'b1, 1'b0);
            n_cmp++;
            if (act() !== exp_o) begin
                n_err++;
                $display("FAIL post_reset c%0d: got %h required %h", i, act(), exp_o);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_drive();
        test_release_only();
        test_coalesce();
        test_enable_abort();
        test_refresh();
        test_random();
        test_reset_mid_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
